cyq_sm_minmax: RTL

Sequential signed-value tracker that sits downstream of the 4-bit sign-magnitude comparator stage. It accepts a stream of 4-bit sign-magnitude samples and keeps the running maximum and minimum. For each sample it registers a three-way compare result against the previous sample, using the same Q encoding as the comparator stage. It also counts accepted samples and flags new extremes.

---
 rtl/cyq_cmp_pkg.sv | 31 +++
 rtl/cyq_sm_cmp.sv | 31 +++
 rtl/cyq_sm_minmax.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cyq_cmp_pkg.sv
// cyq_cmp_pkg
// Shared definitions for the 4-bit sign-magnitude comparator family:
//   - Q encoding (one-hot greater / equal / less)
//   - negative-zero constant
//   - tracker state enum
//   - sm_canon: folds -0 onto +0
//   - sm_key: maps a canonical sign-magnitude value to an unsigned ordering key
package cyq_cmp_pkg;

  localparam logic [2:0] Q_GT = 3'b100;
  localparam logic [2:0] Q_EQ = 3'b010;
  localparam logic [2:0] Q_LT = 3'b001;

  localparam logic [3:0] SM_NEG_ZERO = 4'b1000;

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_e;

  function automatic logic [3:0] sm_canon(input logic [3:0] v);
    return (v == SM_NEG_ZERO) ? 4'b0000 : v;
  endfunction

  // Positives map to 8..15 and negatives to 0..7.
  // Inverting a negative magnitude puts -7 at the bottom of the range.
  function automatic logic [3:0] sm_key(input logic [3:0] v);
    return {~v[3], (v[3] ? ~v[2:0] : v[2:0])};
  endfunction

endpackage

// File: rtl/cyq_sm_cmp.sv
// cyq_sm_cmp
// Combinational three-way compare of two 4-bit sign-magnitude values.
// Both inputs are canonicalised first, so -0 and +0 compare equal.
// Ports:
//   a_i  4  left operand
//   b_i  4  right operand
//   q_o  3  one-hot result of a vs b: Q_GT / Q_EQ / Q_LT
module cyq_sm_cmp
  import cyq_cmp_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [2:0] q_o
);

  logic [3:0] key_a;
  logic [3:0] key_b;

  assign key_a = sm_key(sm_canon(a_i));
  assign key_b = sm_key(sm_canon(b_i));

  always_comb begin
    q_o = Q_EQ;
    if (key_a > key_b) begin
      q_o = Q_GT;
    end else if (key_a < key_b) begin
      q_o = Q_LT;
    end
  end

endmodule

// File: rtl/cyq_sm_minmax.sv
// cyq_sm_minmax
// Running max/min tracker for a stream of 4-bit sign-magnitude samples.
// Every sample is registered with a three-way compare against the
// previous sample. The block also counts accepted samples and pulses
// when a sample sets a new extreme.
//
// Ports:
//   CLK       in   1      system clock, rising edge
//   RESET_N   in   1      asynchronous active-low reset
//   CLR       in   1      synchronous clear; with VALID the sample loads as first
//   VALID     in   1      DIN holds a sample; every VALID cycle is accepted
//   DIN       in   4      sample, sign-magnitude
//   MAX       out  4      running maximum, canonical
//   MIN       out  4      running minimum, canonical
//   Q         out  3      current vs previous sample, one-hot GT/EQ/LT
//   NEW_EXT   out  1      one-cycle pulse when MAX or MIN is updated
//   CNT       out  CNT_W  samples accepted since reset or clear
//   FULL_TRK  out  1      state is TRACK; this is the state debug view
//
// Handshake: VALID has no ready. A sample is consumed on every rising
// CLK edge where VALID is high, and its effects appear after that edge.
//
// Macro CYQ_MINMAX_SAT_EN: when defined, CNT saturates at all-ones.
// When it is undefined, CNT wraps to zero.
module cyq_sm_minmax
  import cyq_cmp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             VALID,
  input  logic [3:0]       DIN,
  output logic [3:0]       MAX,
  output logic [3:0]       MIN,
  output logic [2:0]       Q,
  output logic             NEW_EXT,
  output logic [CNT_W-1:0] CNT,
  output logic             FULL_TRK
);

  state_e           state_q;
  logic [3:0]       max_q;
  logic [3:0]       min_q;
  logic [3:0]       prev_q;
  logic [2:0]       q_q;
  logic             new_ext_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0] sample;
  logic [2:0] q_prev;
  logic [2:0] q_max;
  logic [2:0] q_min;
  logic       upd_max;
  logic       upd_min;

  assign sample = sm_canon(DIN);

  cyq_sm_cmp u_cmp_prev (.a_i(sample), .b_i(prev_q), .q_o(q_prev));
  cyq_sm_cmp u_cmp_max  (.a_i(sample), .b_i(max_q),  .q_o(q_max));
  cyq_sm_cmp u_cmp_min  (.a_i(sample), .b_i(min_q),  .q_o(q_min));

  assign upd_max = (q_max == Q_GT);
  assign upd_min = (q_min == Q_LT);

  // Sample-count increment for the TRACK state.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
`ifdef CYQ_MINMAX_SAT_EN
    if (&cnt_q) begin
      cnt_d = cnt_q;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= EMPTY;
      max_q     <= 4'b0000;
      min_q     <= 4'b0000;
      prev_q    <= 4'b0000;
      q_q       <= Q_EQ;
      new_ext_q <= 1'b0;
      cnt_q     <= '0;
    end else if (CLR && !VALID) begin
      state_q   <= EMPTY;
      max_q     <= 4'b0000;
      min_q     <= 4'b0000;
      prev_q    <= 4'b0000;
      q_q       <= Q_EQ;
      new_ext_q <= 1'b0;
      cnt_q     <= '0;
    end else if (VALID && (CLR || state_q == EMPTY)) begin
      // A clear with VALID behaves like a clear followed by a first sample.
      state_q   <= TRACK;
      max_q     <= sample;
      min_q     <= sample;
      prev_q    <= sample;
      q_q       <= Q_EQ;
      new_ext_q <= 1'b1;
      cnt_q     <= CNT_W'(1);
    end else if (VALID) begin
      state_q   <= TRACK;
      if (upd_max) max_q <= sample;
      if (upd_min) min_q <= sample;
      prev_q    <= sample;
      q_q       <= q_prev;
      new_ext_q <= upd_max || upd_min;
      cnt_q     <= cnt_d;
    end else begin
      new_ext_q <= 1'b0;
    end
  end

  assign MAX      = max_q;
  assign MIN      = min_q;
  assign Q        = q_q;
  assign NEW_EXT  = new_ext_q;
  assign CNT      = cnt_q;
  assign FULL_TRK = (state_q == TRACK);

endmodule
